// File: rtl/int_responder.sv
// int_responder: accepts FIQ/IRQ at instruction boundaries, acknowledges, then runs the exception entry sequence
module int_responder #(
  parameter logic [31:0] FIQ_VECTOR = 32'h0000_001C,
  parameter logic [31:0] IRQ_VECTOR = 32'h0000_0018,
  parameter logic [31:0] LR_OFFSET  = 32'd4
) (
  input  logic        clk,
  input  logic        Rst_n,
  input  logic        INT_fiq,
  input  logic        INT_irq,
  input  logic [31:0] CPSR,
  input  logic        Inst_done,
  input  logic [31:0] PC_next,
  output logic        INTA_fiq,
  output logic        INTA_irq,
  output logic        Stall,
  output logic [4:0]  Bank_mode,
  output logic        SPSR_we,
  output logic [31:0] SPSR_wdata,
  output logic        LR_we,
  output logic [31:0] LR_wdata,
  output logic        CPSR_we,
  output logic [31:0] CPSR_wdata,
  output logic        PC_we,
  output logic [31:0] PC_wdata
);
  typedef enum logic [1:0] {IDLE, ACK, SAVE, JUMP} state_t;
  state_t      state_q, state_d;
  logic        is_fiq_q;
  logic [31:0] cpsr_q, ret_q;
  logic        pend_f, pend_i, accept;
  logic [4:0]  mode;
  assign pend_f = INT_fiq & ~CPSR[6];
  assign pend_i = INT_irq & ~CPSR[7];
  assign accept = (state_q == IDLE) & Inst_done & (pend_f | pend_i);
  assign mode   = is_fiq_q ? 5'b10001 : 5'b10010;
  // State register plus snapshot of the request, CPSR and return address at acceptance
  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= IDLE;
      is_fiq_q <= 1'b0;
      cpsr_q   <= '0;
      ret_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        is_fiq_q <= pend_f;
        cpsr_q   <= CPSR;
        ret_q    <= PC_next + LR_OFFSET;
      end
    end
  end
  // Next state and per-phase outputs; everything is zero unless the phase drives it
  always_comb begin
    state_d    = state_q;
    INTA_fiq   = 1'b0;
    INTA_irq   = 1'b0;
    Stall      = 1'b0;
    Bank_mode  = '0;
    SPSR_we    = 1'b0;
    SPSR_wdata = '0;
    LR_we      = 1'b0;
    LR_wdata   = '0;
    CPSR_we    = 1'b0;
    CPSR_wdata = '0;
    PC_we      = 1'b0;
    PC_wdata   = '0;
    case (state_q)
      IDLE: state_d = accept ? ACK : IDLE;
      ACK: begin
        state_d  = SAVE;
        Stall    = 1'b1;
        INTA_fiq = is_fiq_q;
        INTA_irq = ~is_fiq_q;
      end
      SAVE: begin
        state_d    = JUMP;
        Stall      = 1'b1;
        Bank_mode  = mode;
        SPSR_we    = 1'b1;
        SPSR_wdata = cpsr_q;
        LR_we      = 1'b1;
        LR_wdata   = ret_q;
      end
      JUMP: begin
        state_d    = IDLE;
        Stall      = 1'b1;
        CPSR_we    = 1'b1;
        CPSR_wdata = {cpsr_q[31:8], 1'b1, is_fiq_q | cpsr_q[6], 1'b0, mode};
        PC_we      = 1'b1;
        PC_wdata   = is_fiq_q ? FIQ_VECTOR : IRQ_VECTOR;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_int_responder.sv
// tb_int_responder: directed and random checks of int_responder against a queue-based expectation model
module tb_int_responder;
  logic        clk = 0, Rst_n = 0;
  logic        INT_fiq = 0, INT_irq = 0, Inst_done = 0;
  logic [31:0] CPSR = 0, PC_next = 0;
  logic        INTA_fiq, INTA_irq, Stall, SPSR_we, LR_we, CPSR_we, PC_we;
  logic [4:0]  Bank_mode;
  logic [31:0] SPSR_wdata, LR_wdata, CPSR_wdata, PC_wdata;
  int          checks = 0, errors = 0;
  logic [31:0] last_spsr, last_lr, last_cpsr, last_pc, last_bank;
  int          ackf_seen, acki_seen, busy_seen;

  typedef struct {
    logic        inta_f, inta_i, stall, chk_bank;
    logic [4:0]  bank;
    logic        spsr_we, lr_we, cpsr_we, pc_we;
    logic [31:0] spsr, lr, cpsr, pc;
  } exp_t;
  exp_t exp_q[$];

  int_responder dut (
    .clk(clk), .Rst_n(Rst_n), .INT_fiq(INT_fiq), .INT_irq(INT_irq), .CPSR(CPSR),
    .Inst_done(Inst_done), .PC_next(PC_next), .INTA_fiq(INTA_fiq), .INTA_irq(INTA_irq),
    .Stall(Stall), .Bank_mode(Bank_mode), .SPSR_we(SPSR_we), .SPSR_wdata(SPSR_wdata),
    .LR_we(LR_we), .LR_wdata(LR_wdata), .CPSR_we(CPSR_we), .CPSR_wdata(CPSR_wdata),
    .PC_we(PC_we), .PC_wdata(PC_wdata)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t zero_exp();
    exp_t e = '{default: '0};
    e.chk_bank = 1'b1;
    return e;
  endfunction

  task automatic compare(exp_t e);
    check("inta_fiq", INTA_fiq, e.inta_f);
    check("inta_irq", INTA_irq, e.inta_i);
    check("stall", Stall, e.stall);
    if (e.chk_bank) check("bank_mode", Bank_mode, e.bank);
    check("spsr_we", SPSR_we, e.spsr_we);
    check("spsr_wdata", SPSR_wdata, e.spsr);
    check("lr_we", LR_we, e.lr_we);
    check("lr_wdata", LR_wdata, e.lr);
    check("cpsr_we", CPSR_we, e.cpsr_we);
    check("cpsr_wdata", CPSR_wdata, e.cpsr);
    check("pc_we", PC_we, e.pc_we);
    check("pc_wdata", PC_wdata, e.pc);
  endtask

  // Queues the three post-acceptance cycles an exception entry must produce
  task automatic enqueue_entry(logic fiq, logic [31:0] cpsr, logic [31:0] pcn);
    exp_t a = zero_exp(), s = zero_exp(), j = zero_exp();
    logic [4:0] m = fiq ? 5'd17 : 5'd18;
    a.inta_f = fiq; a.inta_i = !fiq; a.stall = 1;
    s.stall = 1; s.bank = m; s.spsr_we = 1; s.spsr = cpsr; s.lr_we = 1; s.lr = pcn + 32'd4;
    j.stall = 1; j.chk_bank = 0; j.cpsr_we = 1; j.pc_we = 1;
    j.pc = fiq ? 32'h1C : 32'h18;
    j.cpsr = (cpsr & ~32'hFF) | 32'h80 | (fiq ? 32'h40 : (cpsr & 32'h40)) | {27'd0, m};
    exp_q.push_back(a); exp_q.push_back(s); exp_q.push_back(j);
  endtask

  // One clock: drive inputs, check at negedge, update model, advance past the next rising edge
  task automatic step(logic f, logic i, logic [31:0] c, logic d, logic [31:0] p);
    exp_t e;
    logic idle;
    INT_fiq = f; INT_irq = i; CPSR = c; Inst_done = d; PC_next = p;
    @(negedge clk);
    idle = (exp_q.size() == 0);
    e = idle ? zero_exp() : exp_q.pop_front();
    compare(e);
    if (INTA_fiq) ackf_seen++;
    if (INTA_irq) acki_seen++;
    if (Stall) busy_seen++;
    if (SPSR_we) begin last_spsr = SPSR_wdata; last_lr = LR_wdata; last_bank = {27'd0, Bank_mode}; end
    if (PC_we) begin last_pc = PC_wdata; last_cpsr = CPSR_wdata; end
    if (idle && d && ((f && !c[6]) || (i && !c[7]))) enqueue_entry(f && !c[6], c, p);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_steps(int n);
    for (int k = 0; k < n; k++) step(0, 0, 32'h10, 0, 32'h0);
  endtask

  initial begin
    #12;
    compare(zero_exp());
    @(posedge clk); #1;
    Rst_n = 1;

    // IRQ entry with known values
    step(0, 1, 32'h10, 1, 32'h100);
    idle_steps(4);
    check("t1_spsr", last_spsr, 32'h10);
    check("t1_lr", last_lr, 32'h104);
    check("t1_bank", last_bank, 32'h12);
    check("t1_cpsr", last_cpsr, 32'h92);
    check("t1_pc", last_pc, 32'h18);
    check("t1_inta_irq_count", acki_seen, 1);

    // FIQ wins over IRQ
    ackf_seen = 0; acki_seen = 0;
    step(1, 1, 32'h10, 1, 32'h200);
    idle_steps(4);
    check("t2_inta_fiq_count", ackf_seen, 1);
    check("t2_inta_irq_count", acki_seen, 0);
    check("t2_cpsr", last_cpsr, 32'hD1);
    check("t2_pc", last_pc, 32'h1C);

    // IRQ masked by I bit, then unmasked
    ackf_seen = 0; acki_seen = 0; busy_seen = 0;
    for (int k = 0; k < 5; k++) step(0, 1, 32'h90, 1, 32'h300);
    check("t3_masked_busy", busy_seen, 0);
    check("t3_masked_inta", acki_seen, 0);
    step(0, 1, 32'h10, 1, 32'h300);
    idle_steps(4);
    check("t3_unmasked_inta", acki_seen, 1);

    // Pending FIQ waits for the instruction boundary
    busy_seen = 0; ackf_seen = 0;
    for (int k = 0; k < 5; k++) step(1, 0, 32'h10, 0, 32'h400);
    check("t4_wait_busy", busy_seen, 0);
    step(1, 0, 32'h10, 1, 32'h400);
    idle_steps(4);
    check("t4_inta_fiq", ackf_seen, 1);

    // Reset asserted during SAVE aborts the entry
    step(0, 1, 32'h10, 1, 32'h500);
    step(0, 0, 32'h10, 0, 32'h0);
    Rst_n = 0;
    #1;
    exp_q.delete();
    compare(zero_exp());
    #1 Rst_n = 1;
    last_pc = '0;
    idle_steps(4);
    check("t5_no_jump_after_reset", last_pc, 32'h0);

    // FIQ rising during IRQ entry is taken after the IRQ completes
    ackf_seen = 0; acki_seen = 0;
    step(0, 1, 32'h10, 1, 32'h600);
    step(0, 0, 32'h10, 0, 32'h0);
    step(1, 0, 32'h10, 1, 32'h0);
    step(1, 0, 32'h10, 1, 32'h0);
    check("t6_irq_cpsr_f_clear", last_cpsr, 32'h92);
    check("t6_no_preempt", ackf_seen, 0);
    step(1, 0, 32'h92, 1, 32'h604);
    idle_steps(4);
    check("t6_fiq_taken", ackf_seen, 1);
    check("t6_fiq_pc", last_pc, 32'h1C);
    check("t6_fiq_lr", last_lr, 32'h608);

    // Random traffic
    for (int k = 0; k < 400; k++)
      step($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 4,
           {$urandom_range(0, 255), 8'h00} | ($urandom & 32'hE0) | 32'h10,
           $urandom_range(0, 1) == 1, $urandom & 32'hFFFF_FFFC);
    idle_steps(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
